// File: rtl/etapa_idex_riesgos_pkg.sv
// Shared definitions for the ID/EX register with load-use hazard detection:
// default widths and the control word loaded when EX receives a bubble.
package etapa_idex_riesgos_pkg;

    localparam int BITS_REGS     = 5;
    localparam int BITS_DATA     = 32;
    localparam int BITS_ALUOP    = 3;
    localparam int BITS_STALLCNT = 16;

    // Single-bit EX control signals; alu_op is kept apart because its width is a parameter.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_dst;
        logic alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/etapa_idex_riesgos_if.sv
// Bundle between decode, the ID/EX register and execute: ID-side fields in,
// EX-side fields and pipeline-control enables out.
interface etapa_idex_riesgos_if #(
    parameter int BITS_REGS     = etapa_idex_riesgos_pkg::BITS_REGS,
    parameter int BITS_DATA     = etapa_idex_riesgos_pkg::BITS_DATA,
    parameter int BITS_ALUOP    = etapa_idex_riesgos_pkg::BITS_ALUOP,
    parameter int BITS_STALLCNT = etapa_idex_riesgos_pkg::BITS_STALLCNT
);
    logic                     i_step;
    logic                     i_flush;
    logic [BITS_REGS-1:0]     i_ID_rs;
    logic [BITS_REGS-1:0]     i_ID_rt;
    logic [BITS_REGS-1:0]     i_ID_rd;
    logic                     i_ID_uses_rt;
    logic [BITS_DATA-1:0]     i_ID_data_a;
    logic [BITS_DATA-1:0]     i_ID_data_b;
    logic [BITS_DATA-1:0]     i_ID_imm;
    logic                     i_ID_reg_write;
    logic                     i_ID_mem_read;
    logic                     i_ID_mem_write;
    logic                     i_ID_mem_to_reg;
    logic                     i_ID_reg_dst;
    logic                     i_ID_alu_src;
    logic [BITS_ALUOP-1:0]    i_ID_alu_op;

    logic                     o_pc_write;
    logic                     o_IFID_write;
    logic                     o_stall;
    logic                     o_EX_valid;
    logic [BITS_REGS-1:0]     o_EX_rs;
    logic [BITS_REGS-1:0]     o_EX_rt;
    logic [BITS_REGS-1:0]     o_EX_rd;
    logic [BITS_DATA-1:0]     o_EX_data_a;
    logic [BITS_DATA-1:0]     o_EX_data_b;
    logic [BITS_DATA-1:0]     o_EX_imm;
    logic                     o_EX_reg_write;
    logic                     o_EX_mem_read;
    logic                     o_EX_mem_write;
    logic                     o_EX_mem_to_reg;
    logic                     o_EX_reg_dst;
    logic                     o_EX_alu_src;
    logic [BITS_ALUOP-1:0]    o_EX_alu_op;
    logic [BITS_STALLCNT-1:0] o_stall_count;

    modport master (
        output i_step, i_flush,
        output i_ID_rs, i_ID_rt, i_ID_rd, i_ID_uses_rt,
        output i_ID_data_a, i_ID_data_b, i_ID_imm,
        output i_ID_reg_write, i_ID_mem_read, i_ID_mem_write,
        output i_ID_mem_to_reg, i_ID_reg_dst, i_ID_alu_src, i_ID_alu_op,
        input  o_pc_write, o_IFID_write, o_stall, o_EX_valid,
        input  o_EX_rs, o_EX_rt, o_EX_rd,
        input  o_EX_data_a, o_EX_data_b, o_EX_imm,
        input  o_EX_reg_write, o_EX_mem_read, o_EX_mem_write,
        input  o_EX_mem_to_reg, o_EX_reg_dst, o_EX_alu_src, o_EX_alu_op,
        input  o_stall_count
    );

    modport slave (
        input  i_step, i_flush,
        input  i_ID_rs, i_ID_rt, i_ID_rd, i_ID_uses_rt,
        input  i_ID_data_a, i_ID_data_b, i_ID_imm,
        input  i_ID_reg_write, i_ID_mem_read, i_ID_mem_write,
        input  i_ID_mem_to_reg, i_ID_reg_dst, i_ID_alu_src, i_ID_alu_op,
        output o_pc_write, o_IFID_write, o_stall, o_EX_valid,
        output o_EX_rs, o_EX_rt, o_EX_rd,
        output o_EX_data_a, o_EX_data_b, o_EX_imm,
        output o_EX_reg_write, o_EX_mem_read, o_EX_mem_write,
        output o_EX_mem_to_reg, o_EX_reg_dst, o_EX_alu_src, o_EX_alu_op,
        output o_stall_count
    );

endinterface

// File: rtl/etapa_idex_riesgos_detector_riesgo_carga.sv
// Load-use hazard term: the instruction in EX is a load whose destination
// (rt, never $zero) is a source of the instruction currently in ID.
module detector_riesgo_carga #(
    parameter int BITS_REGS = etapa_idex_riesgos_pkg::BITS_REGS
) (
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [BITS_REGS-1:0] ex_rt,
    input  logic [BITS_REGS-1:0] id_rs,
    input  logic [BITS_REGS-1:0] id_rt,
    input  logic                 id_uses_rt,
    output logic                 hazard
);

    logic reads_rs;
    logic reads_rt;

    assign reads_rs = (ex_rt == id_rs);
    assign reads_rt = id_uses_rt & (ex_rt == id_rt);
    assign hazard   = ex_valid & ex_mem_read & (ex_rt != '0) & (reads_rs | reads_rt);

endmodule

// File: rtl/etapa_idex_riesgos.sv
// ID/EX pipeline register: latches decoded operands/control, inserts a bubble
// on flush or load-use hazard, and counts stall cycles (saturating).
module etapa_idex_riesgos #(
    parameter int BITS_REGS     = etapa_idex_riesgos_pkg::BITS_REGS,
    parameter int BITS_DATA     = etapa_idex_riesgos_pkg::BITS_DATA,
    parameter int BITS_ALUOP    = etapa_idex_riesgos_pkg::BITS_ALUOP,
    parameter int BITS_STALLCNT = etapa_idex_riesgos_pkg::BITS_STALLCNT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    etapa_idex_riesgos_if.slave   bus
);
    import etapa_idex_riesgos_pkg::*;

    logic                     ex_valid;
    logic [BITS_REGS-1:0]     ex_rs;
    logic [BITS_REGS-1:0]     ex_rt;
    logic [BITS_REGS-1:0]     ex_rd;
    logic [BITS_DATA-1:0]     ex_data_a;
    logic [BITS_DATA-1:0]     ex_data_b;
    logic [BITS_DATA-1:0]     ex_imm;
    ctrl_t                    ex_ctrl;
    logic [BITS_ALUOP-1:0]    ex_alu_op;
    logic [BITS_STALLCNT-1:0] stall_count;

    ctrl_t id_ctrl;
    logic  hazard;
    logic  stall;
    logic  bubble;

    assign id_ctrl = '{
        reg_write:  bus.i_ID_reg_write,
        mem_read:   bus.i_ID_mem_read,
        mem_write:  bus.i_ID_mem_write,
        mem_to_reg: bus.i_ID_mem_to_reg,
        reg_dst:    bus.i_ID_reg_dst,
        alu_src:    bus.i_ID_alu_src
    };

    detector_riesgo_carga #(
        .BITS_REGS (BITS_REGS)
    ) u_detector (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (bus.i_ID_rs),
        .id_rt       (bus.i_ID_rt),
        .id_uses_rt  (bus.i_ID_uses_rt),
        .hazard      (hazard)
    );

    // A flush overrides the hazard: the stalled instruction is being squashed anyway.
    assign stall  = bus.i_step & hazard & ~bus.i_flush;
    assign bubble = bus.i_flush | hazard;

    assign bus.o_stall      = stall;
    assign bus.o_pc_write   = bus.i_step & ~stall;
    assign bus.o_IFID_write = bus.i_step & ~stall;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_data_a <= '0;
            ex_data_b <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= CTRL_BUBBLE;
            ex_alu_op <= '0;
        end else if (bus.i_step) begin
            ex_valid  <= ~bubble;
            ex_rs     <= bubble ? '0 : bus.i_ID_rs;
            ex_rt     <= bubble ? '0 : bus.i_ID_rt;
            ex_rd     <= bubble ? '0 : bus.i_ID_rd;
            ex_data_a <= bubble ? '0 : bus.i_ID_data_a;
            ex_data_b <= bubble ? '0 : bus.i_ID_data_b;
            ex_imm    <= bubble ? '0 : bus.i_ID_imm;
            ex_ctrl   <= bubble ? CTRL_BUBBLE : id_ctrl;
            ex_alu_op <= bubble ? '0 : bus.i_ID_alu_op;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + BITS_STALLCNT'(1);
        end
    end

    assign bus.o_EX_valid      = ex_valid;
    assign bus.o_EX_rs         = ex_rs;
    assign bus.o_EX_rt         = ex_rt;
    assign bus.o_EX_rd         = ex_rd;
    assign bus.o_EX_data_a     = ex_data_a;
    assign bus.o_EX_data_b     = ex_data_b;
    assign bus.o_EX_imm        = ex_imm;
    assign bus.o_EX_reg_write  = ex_ctrl.reg_write;
    assign bus.o_EX_mem_read   = ex_ctrl.mem_read;
    assign bus.o_EX_mem_write  = ex_ctrl.mem_write;
    assign bus.o_EX_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.o_EX_reg_dst    = ex_ctrl.reg_dst;
    assign bus.o_EX_alu_src    = ex_ctrl.alu_src;
    assign bus.o_EX_alu_op     = ex_alu_op;
    assign bus.o_stall_count   = stall_count;

endmodule

// File: tb/tb_etapa_idex_riesgos.sv
// Self-checking bench for etapa_idex_riesgos: directed scenarios plus random
// traffic against a behavioural model of the EX slot and stall counter.
module tb_etapa_idex_riesgos;

    localparam int BR       = 5;
    localparam int BD       = 32;
    localparam int BA       = 3;
    localparam int BS       = 16;
    localparam int BS_SMALL = 3;
    localparam int CNT_MAX  = 65535;

    typedef struct packed {
        logic          valid;
        logic [BR-1:0] rs, rt, rd;
        logic [BD-1:0] data_a, data_b, imm;
        logic          reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src;
        logic [BA-1:0] alu_op;
    } ex_t;

    typedef struct packed {
        logic [BR-1:0] rs, rt, rd;
        logic          uses_rt;
        logic [BD-1:0] data_a, data_b, imm;
        logic          reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src;
        logic [BA-1:0] alu_op;
    } id_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    etapa_idex_riesgos_if #(.BITS_REGS(BR), .BITS_DATA(BD), .BITS_ALUOP(BA), .BITS_STALLCNT(BS)) bus ();
    etapa_idex_riesgos_if #(.BITS_REGS(BR), .BITS_DATA(BD), .BITS_ALUOP(BA), .BITS_STALLCNT(BS_SMALL)) bus_s ();

    etapa_idex_riesgos #(.BITS_REGS(BR), .BITS_DATA(BD), .BITS_ALUOP(BA), .BITS_STALLCNT(BS)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    etapa_idex_riesgos #(.BITS_REGS(BR), .BITS_DATA(BD), .BITS_ALUOP(BA), .BITS_STALLCNT(BS_SMALL)) dut_s (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus_s)
    );

    int   checks;
    int   errors;
    ex_t  m;
    int   m_cnt;
    id_t  cur_id;
    logic cur_step;
    logic cur_flush;

    function automatic ex_t dut_ex();
        ex_t e;
        e = '{valid: bus.o_EX_valid, rs: bus.o_EX_rs, rt: bus.o_EX_rt, rd: bus.o_EX_rd,
              data_a: bus.o_EX_data_a, data_b: bus.o_EX_data_b, imm: bus.o_EX_imm,
              reg_write: bus.o_EX_reg_write, mem_read: bus.o_EX_mem_read,
              mem_write: bus.o_EX_mem_write, mem_to_reg: bus.o_EX_mem_to_reg,
              reg_dst: bus.o_EX_reg_dst, alu_src: bus.o_EX_alu_src, alu_op: bus.o_EX_alu_op};
        return e;
    endfunction

    function automatic logic [2:0] dut_comb();
        return {bus.o_stall, bus.o_pc_write, bus.o_IFID_write};
    endfunction

    // EX holds a real load writing a nonzero register that the ID instruction reads.
    function automatic bit model_hazard();
        bit load_in_ex;
        bit rs_dep;
        bit rt_dep;
        load_in_ex = m.valid && m.mem_read && (m.rt != 0);
        rs_dep     = (m.rt == cur_id.rs);
        rt_dep     = cur_id.uses_rt && (m.rt == cur_id.rt);
        return load_in_ex && (rs_dep || rt_dep);
    endfunction

    function automatic logic [2:0] model_comb();
        bit st;
        st = cur_step && model_hazard() && !cur_flush;
        return {st, cur_step && !st, cur_step && !st};
    endfunction

    function automatic id_t mk_id(input int rs, input int rt, input int rd, input bit uses_rt,
                                  input bit load, input logic [BD-1:0] a, input logic [BD-1:0] b);
        id_t id;
        id.rs = BR'(rs);
        id.rt = BR'(rt);
        id.rd = BR'(rd);
        id.uses_rt    = uses_rt;
        id.data_a     = a;
        id.data_b     = b;
        id.imm        = 32'h100 + BD'(rd);
        id.reg_write  = 1'b1;
        id.mem_read   = load;
        id.mem_write  = 1'b0;
        id.mem_to_reg = load;
        id.reg_dst    = !load;
        id.alu_src    = load;
        id.alu_op     = load ? 3'd0 : 3'd2;
        return id;
    endfunction

    function automatic id_t rand_id();
        id_t id;
        id.rs         = BR'($urandom_range(0, 7));
        id.rt         = BR'($urandom_range(0, 7));
        id.rd         = BR'($urandom);
        id.uses_rt    = 1'($urandom);
        id.data_a     = $urandom;
        id.data_b     = $urandom;
        id.imm        = $urandom;
        id.reg_write  = 1'($urandom);
        id.mem_read   = ($urandom_range(0, 2) == 0);
        id.mem_write  = 1'($urandom);
        id.mem_to_reg = 1'($urandom);
        id.reg_dst    = 1'($urandom);
        id.alu_src    = 1'($urandom);
        id.alu_op     = BA'($urandom);
        return id;
    endfunction

    task automatic apply(input id_t id, input logic step, input logic flush);
        cur_id = id;
        cur_step = step;
        cur_flush = flush;
        bus.i_step          = step;
        bus.i_flush         = flush;
        bus.i_ID_rs         = id.rs;
        bus.i_ID_rt         = id.rt;
        bus.i_ID_rd         = id.rd;
        bus.i_ID_uses_rt    = id.uses_rt;
        bus.i_ID_data_a     = id.data_a;
        bus.i_ID_data_b     = id.data_b;
        bus.i_ID_imm        = id.imm;
        bus.i_ID_reg_write  = id.reg_write;
        bus.i_ID_mem_read   = id.mem_read;
        bus.i_ID_mem_write  = id.mem_write;
        bus.i_ID_mem_to_reg = id.mem_to_reg;
        bus.i_ID_reg_dst    = id.reg_dst;
        bus.i_ID_alu_src    = id.alu_src;
        bus.i_ID_alu_op     = id.alu_op;
    endtask

    // Advance one edge and move the model: flush and hazard both leave a bubble,
    // only an unflushed hazard counts as a stall.
    task automatic tick();
        bit hz;
        @(posedge clk);
        hz = model_hazard();
        if (cur_step) begin
            if (cur_flush) begin
                m = '0;
            end else if (hz) begin
                m = '0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m = '{valid: 1'b1, rs: cur_id.rs, rt: cur_id.rt, rd: cur_id.rd,
                      data_a: cur_id.data_a, data_b: cur_id.data_b, imm: cur_id.imm,
                      reg_write: cur_id.reg_write, mem_read: cur_id.mem_read,
                      mem_write: cur_id.mem_write, mem_to_reg: cur_id.mem_to_reg,
                      reg_dst: cur_id.reg_dst, alu_src: cur_id.alu_src, alu_op: cur_id.alu_op};
            end
        end
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (dut_ex() !== ex_t'(0)) begin
            errors++; $display("FAIL reset_ex: got %h want 0", dut_ex());
        end
        checks++;
        if (bus.o_stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", bus.o_stall_count);
        end
        checks++;
        if (dut_comb() !== 3'b011) begin
            errors++; $display("FAIL reset_comb_step1: got %b want 011", dut_comb());
        end
        apply(cur_id, 1'b0, 1'b0);
        #1;
        checks++;
        if (dut_comb() !== 3'b000) begin
            errors++; $display("FAIL reset_comb_step0: got %b want 000", dut_comb());
        end
        apply(cur_id, 1'b1, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        apply(mk_id(2, 3, 4, 1'b1, 1'b0, 32'h10, 32'h20), 1'b1, 1'b0);
        #1;
        checks++;
        if (dut_comb() !== 3'b011) begin
            errors++; $display("FAIL add_comb: got %b want 011", dut_comb());
        end
        tick();
        checks++;
        if (dut_ex() !== m) begin
            errors++; $display("FAIL add_ex: got %h want %h", dut_ex(), m);
        end
        checks++;
        if ({bus.o_EX_valid, bus.o_EX_reg_write, bus.o_EX_rs, bus.o_EX_rt, bus.o_EX_rd,
             bus.o_EX_data_a, bus.o_EX_data_b} !== {1'b1, 1'b1, 5'd2, 5'd3, 5'd4, 32'h10, 32'h20}) begin
            errors++; $display("FAIL add_fields: got rs=%0d rt=%0d rd=%0d a=%h b=%h v=%b",
                               bus.o_EX_rs, bus.o_EX_rt, bus.o_EX_rd, bus.o_EX_data_a,
                               bus.o_EX_data_b, bus.o_EX_valid);
        end
    endtask

    task automatic test_load_use();
        apply(mk_id(1, 5, 0, 1'b0, 1'b1, 32'h4, 32'h0), 1'b1, 1'b0);
        tick();
        apply(mk_id(5, 7, 8, 1'b1, 1'b0, 32'h55, 32'h66), 1'b1, 1'b0);
        #1;
        checks++;
        if (dut_comb() !== 3'b100) begin
            errors++; $display("FAIL lu_stall: got %b want 100", dut_comb());
        end
        tick();
        checks++;
        if (dut_ex() !== ex_t'(0)) begin
            errors++; $display("FAIL lu_bubble: got %h want 0", dut_ex());
        end
        checks++;
        if (bus.o_stall_count !== 16'd1) begin
            errors++; $display("FAIL lu_cnt: got %0d want 1", bus.o_stall_count);
        end
        checks++;
        if (dut_comb() !== 3'b011) begin
            errors++; $display("FAIL lu_second_cycle: got %b want 011", dut_comb());
        end
        tick();
        checks++;
        if (dut_ex() !== m || bus.o_EX_rs !== 5'd5 || bus.o_EX_valid !== 1'b1) begin
            errors++; $display("FAIL lu_relatch: got %h want %h", dut_ex(), m);
        end
    endtask

    task automatic test_no_stall();
        apply(mk_id(3, 0, 0, 1'b0, 1'b1, 32'h1, 32'h2), 1'b1, 1'b0);
        tick();
        apply(mk_id(0, 0, 9, 1'b1, 1'b0, 32'h3, 32'h4), 1'b1, 1'b0);
        #1;
        checks++;
        if (dut_comb() !== 3'b011) begin
            errors++; $display("FAIL nostall_r0: got %b want 011", dut_comb());
        end
        tick();
        apply(mk_id(2, 6, 0, 1'b0, 1'b1, 32'h5, 32'h6), 1'b1, 1'b0);
        tick();
        apply(mk_id(1, 6, 10, 1'b0, 1'b0, 32'h7, 32'h8), 1'b1, 1'b0);
        #1;
        checks++;
        if (dut_comb() !== 3'b011) begin
            errors++; $display("FAIL nostall_rt_unused: got %b want 011", dut_comb());
        end
        tick();
        checks++;
        if (dut_ex() !== m) begin
            errors++; $display("FAIL nostall_ex: got %h want %h", dut_ex(), m);
        end
    endtask

    task automatic test_flush();
        logic [BS-1:0] cnt_before;
        apply(mk_id(0, 5, 0, 1'b0, 1'b1, 32'h9, 32'h0), 1'b1, 1'b0);
        tick();
        cnt_before = BS'(m_cnt);
        apply(mk_id(5, 1, 11, 1'b1, 1'b0, 32'hA, 32'hB), 1'b1, 1'b1);
        #1;
        checks++;
        if (dut_comb() !== 3'b011) begin
            errors++; $display("FAIL flush_comb: got %b want 011", dut_comb());
        end
        tick();
        checks++;
        if (dut_ex() !== ex_t'(0)) begin
            errors++; $display("FAIL flush_bubble: got %h want 0", dut_ex());
        end
        checks++;
        if (bus.o_stall_count !== cnt_before) begin
            errors++; $display("FAIL flush_cnt: got %0d want %0d", bus.o_stall_count, cnt_before);
        end
    endtask

    task automatic test_step_freeze();
        ex_t snap;
        apply(mk_id(0, 5, 0, 1'b0, 1'b1, 32'hC, 32'h0), 1'b1, 1'b0);
        tick();
        snap = m;
        apply(mk_id(5, 5, 12, 1'b1, 1'b0, 32'hD, 32'hE), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (dut_comb() !== 3'b000) begin
                errors++; $display("FAIL freeze_comb[%0d]: got %b want 000", i, dut_comb());
            end
            tick();
            checks++;
            if (dut_ex() !== snap || bus.o_stall_count !== BS'(m_cnt)) begin
                errors++; $display("FAIL freeze_hold[%0d]: got %h cnt %0d want %h cnt %0d",
                                   i, dut_ex(), bus.o_stall_count, snap, m_cnt);
            end
        end
        apply(cur_id, 1'b1, 1'b0);
        #1;
        checks++;
        if (dut_comb() !== 3'b100) begin
            errors++; $display("FAIL freeze_resume: got %b want 100", dut_comb());
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(rand_id(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
            #1;
            checks++;
            if (dut_comb() !== model_comb()) begin
                errors++; $display("FAIL rand_comb[%0d]: got %b want %b", i, dut_comb(), model_comb());
            end
            tick();
            checks++;
            if (dut_ex() !== m || bus.o_stall_count !== BS'(m_cnt)) begin
                errors++; $display("FAIL rand_state[%0d]: got %h cnt %0d want %h cnt %0d",
                                   i, dut_ex(), bus.o_stall_count, m, m_cnt);
            end
        end
    endtask

    // Narrow-counter instance: each load/dependent pair gives one stall; count caps at 7.
    task automatic test_saturation();
        int exp_cnt;
        exp_cnt = 0;
        apply(cur_id, 1'b0, 1'b0);
        bus_s.i_step = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus_s.i_ID_rs = 5'd0; bus_s.i_ID_rt = 5'd5; bus_s.i_ID_mem_read = 1'b1;
            @(posedge clk); #1;
            bus_s.i_ID_rs = 5'd5; bus_s.i_ID_rt = 5'd0; bus_s.i_ID_mem_read = 1'b0;
            #1;
            checks++;
            if (bus_s.o_stall !== 1'b1) begin
                errors++; $display("FAIL sat_stall[%0d]: got %b want 1", k, bus_s.o_stall);
            end
            @(posedge clk); #1;
            if (exp_cnt < 7) exp_cnt++;
            checks++;
            if (bus_s.o_stall_count !== BS_SMALL'(exp_cnt)) begin
                errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, bus_s.o_stall_count, exp_cnt);
            end
        end
        bus_s.i_step = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        apply(mk_id(0, 5, 0, 1'b0, 1'b1, 32'hF, 32'h0), 1'b1, 1'b0);
        tick();
        apply(mk_id(5, 2, 13, 1'b1, 1'b0, 32'h11, 32'h12), 1'b1, 1'b0);
        #1;
        checks++;
        if (dut_comb() !== 3'b100) begin
            errors++; $display("FAIL rms_pre: got %b want 100", dut_comb());
        end
        rst_n = 1'b0;
        m = '0;
        m_cnt = 0;
        #1;
        checks++;
        if (dut_ex() !== ex_t'(0) || bus.o_stall_count !== 16'd0 || bus_s.o_stall_count !== 3'd0) begin
            errors++; $display("FAIL rms_clear: got %h cnt %0d cnt_s %0d want 0",
                               dut_ex(), bus.o_stall_count, bus_s.o_stall_count);
        end
        checks++;
        if (dut_comb() !== 3'b011) begin
            errors++; $display("FAIL rms_comb: got %b want 011", dut_comb());
        end
        rst_n = 1'b1;
        #1;
        tick();
        checks++;
        if (dut_ex() !== m || bus.o_EX_rs !== 5'd5) begin
            errors++; $display("FAIL rms_after: got %h want %h", dut_ex(), m);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m = '0;
        m_cnt = 0;
        apply(rand_id(), 1'b1, 1'b0);
        bus_s.i_step = 1'b0;       bus_s.i_flush = 1'b0;
        bus_s.i_ID_rs = '0;        bus_s.i_ID_rt = '0;         bus_s.i_ID_rd = '0;
        bus_s.i_ID_uses_rt = 1'b0; bus_s.i_ID_data_a = '0;     bus_s.i_ID_data_b = '0;
        bus_s.i_ID_imm = '0;       bus_s.i_ID_reg_write = 1'b0; bus_s.i_ID_mem_read = 1'b0;
        bus_s.i_ID_mem_write = 1'b0; bus_s.i_ID_mem_to_reg = 1'b0;
        bus_s.i_ID_reg_dst = 1'b0; bus_s.i_ID_alu_src = 1'b0;  bus_s.i_ID_alu_op = '0;
        #1 rst_n = 1'b0;
        #11;
        test_reset();
        test_add();
        test_load_use();
        test_no_stall();
        test_flush();
        test_step_freeze();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
